// File: rtl/gb_dma_ctrl.sv
// Multi-mode DMA engine: legacy OAM DMA plus CGB general-purpose and HBlank HDMA
// behind one bus-master port; the MMU hands its buses over while DMA_ACTIVE is high.
module gb_dma_ctrl #(
  parameter int BYTE_CYCLES = 4,
  parameter int SETUP_DELAY = 4,
  parameter int OAM_LEN     = 160,
  parameter int BLOCK_BYTES = 16,
  parameter bit HDMA_EN     = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ADDR,
  input  logic        WR,
  input  logic        RD,
  input  logic [7:0]  MMIO_DATA_out,
  output logic [7:0]  MMIO_DATA_in,
  input  logic [1:0]  PPU_MODE,
  output logic [15:0] DMA_SRC_A,
  output logic        DMA_RD,
  input  logic [7:0]  DMA_D_in,
  output logic [15:0] DMA_DST_A,
  output logic        DMA_WR,
  output logic [7:0]  DMA_D_out,
  output logic        DMA_ACTIVE,
  output logic        OAM_BUSY,
  output logic        CPU_STALL
);
  localparam int CW = 16;
  localparam int IW = 16;

  typedef enum logic [2:0] {
    S_IDLE, S_OAM_SETUP, S_OAM_XFER, S_GP_XFER, S_HB_WAIT, S_HB_XFER
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cyc;
  logic [IW-1:0] r_idx;
  logic [15:0]   r_src, r_dst;
  logic [7:0]    r_ff46, r_h1;
  logic [3:0]    r_h2, r_h4;
  logic [4:0]    r_h3;
  logic [6:0]    r_hlen;
  logic          r_hact, r_hstop, r_cancel, r_pend;
  logic [1:0]    r_ppu_prev;

  state_t        w_nstate, w_done_state;
  logic [CW-1:0] w_ncyc;
  logic          w_wr46, w_wr51, w_wr52, w_wr53, w_wr54, w_wr55, w_cancel;
  logic          w_slot_end, w_blk_last, w_oam_last, w_hb_edge, w_nxfer;
  logic          w_xfer_st, w_hdma_st, w_adv, w_start, w_blk_done;
  logic [7:0]    w_ff55;

  assign w_wr46   = WR && (ADDR == 16'hFF46);
  assign w_wr51   = HDMA_EN && WR && (ADDR == 16'hFF51);
  assign w_wr52   = HDMA_EN && WR && (ADDR == 16'hFF52);
  assign w_wr53   = HDMA_EN && WR && (ADDR == 16'hFF53);
  assign w_wr54   = HDMA_EN && WR && (ADDR == 16'hFF54);
  assign w_wr55   = HDMA_EN && WR && (ADDR == 16'hFF55);
  assign w_cancel = w_wr55 && !MMIO_DATA_out[7];

  assign w_slot_end = (r_cyc == CW'(BYTE_CYCLES - 1));
  assign w_blk_last = (r_idx == IW'(BLOCK_BYTES - 1));
  assign w_oam_last = (r_idx == IW'(OAM_LEN - 1));
  assign w_hb_edge  = (r_ppu_prev != 2'd0) && (PPU_MODE == 2'd0);
  assign w_xfer_st  = (r_state == S_OAM_XFER) || (r_state == S_GP_XFER) || (r_state == S_HB_XFER);
  assign w_hdma_st  = (r_state == S_GP_XFER) || (r_state == S_HB_WAIT) || (r_state == S_HB_XFER);
  // a page rewrite abandons the slot in flight, so its counters must not advance
  assign w_adv      = w_slot_end && w_xfer_st && !((r_state == S_OAM_XFER) && w_wr46);
  assign w_start    = (r_state == S_IDLE) && w_wr55;
  assign w_blk_done = w_blk_last &&
                      ((r_hlen == 7'd0) || ((r_state == S_HB_XFER) && (r_cancel || w_cancel)));
  assign w_done_state = (r_pend || w_wr46) ? S_OAM_SETUP : S_IDLE;

  always_comb begin
    w_nstate = r_state;
    w_ncyc   = r_cyc + CW'(1);
    unique case (r_state)
      S_IDLE: begin
        w_ncyc = '0;
        if (w_wr46)      w_nstate = S_OAM_SETUP;
        else if (w_wr55) w_nstate = MMIO_DATA_out[7] ? S_HB_WAIT : S_GP_XFER;
      end
      S_OAM_SETUP: begin
        if (w_wr46) w_ncyc = '0;
        else if (r_cyc == CW'(SETUP_DELAY - 1)) begin
          w_nstate = S_OAM_XFER;
          w_ncyc   = '0;
        end
      end
      S_OAM_XFER: begin
        if (w_wr46) begin
          w_nstate = S_OAM_SETUP;
          w_ncyc   = '0;
        end else if (w_slot_end) begin
          w_ncyc = '0;
          if (w_oam_last) w_nstate = S_IDLE;
        end
      end
      S_GP_XFER, S_HB_XFER: begin
        if (w_slot_end) begin
          w_ncyc = '0;
          if (w_blk_done)                            w_nstate = w_done_state;
          else if (w_blk_last && r_state == S_HB_XFER) w_nstate = S_HB_WAIT;
        end
      end
      S_HB_WAIT: begin
        w_ncyc = '0;
        if (w_cancel)       w_nstate = w_done_state;
        else if (w_hb_edge) w_nstate = S_HB_XFER;
      end
      default: begin
        w_nstate = S_IDLE;
        w_ncyc   = '0;
      end
    endcase
  end

  assign w_nxfer = (w_nstate == S_OAM_XFER) || (w_nstate == S_GP_XFER) || (w_nstate == S_HB_XFER);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cyc      <= '0;
      r_idx      <= '0;
      r_src      <= '0;
      r_dst      <= '0;
      r_ff46     <= '0;
      r_h1       <= '0;
      r_h2       <= '0;
      r_h3       <= '0;
      r_h4       <= '0;
      r_hlen     <= '0;
      r_hact     <= 1'b0;
      r_hstop    <= 1'b0;
      r_cancel   <= 1'b0;
      r_pend     <= 1'b0;
      r_ppu_prev <= '0;
      DMA_ACTIVE <= 1'b0;
      DMA_RD     <= 1'b0;
      DMA_WR     <= 1'b0;
      OAM_BUSY   <= 1'b0;
      CPU_STALL  <= 1'b0;
    end else begin
      r_state    <= w_nstate;
      r_cyc      <= w_ncyc;
      r_ppu_prev <= PPU_MODE;
      DMA_ACTIVE <= w_nxfer;
      DMA_RD     <= w_nxfer;
      DMA_WR     <= w_nxfer && (w_ncyc == CW'(BYTE_CYCLES - 1));
      OAM_BUSY   <= (w_nstate == S_OAM_XFER);
      CPU_STALL  <= (w_nstate == S_GP_XFER) || (w_nstate == S_HB_XFER);

      if (w_wr46) r_ff46 <= MMIO_DATA_out;
      if (w_wr51) r_h1   <= MMIO_DATA_out;
      if (w_wr52) r_h2   <= MMIO_DATA_out[7:4];
      if (w_wr53) r_h3   <= MMIO_DATA_out[4:0];
      if (w_wr54) r_h4   <= MMIO_DATA_out[7:4];

      if (w_wr46 && w_hdma_st)          r_pend <= 1'b1;
      else if (r_state == S_OAM_SETUP)  r_pend <= 1'b0;

      if (w_start) begin
        r_src    <= {r_h1, r_h2, 4'h0};
        r_dst    <= {3'b100, r_h3, r_h4, 4'h0};
        r_hlen   <= MMIO_DATA_out[6:0];
        r_hact   <= 1'b1;
        r_hstop  <= 1'b0;
        r_cancel <= 1'b0;
        r_idx    <= '0;
      end

      if (r_state == S_OAM_SETUP && w_nstate == S_OAM_XFER) begin
        r_src <= {r_ff46, 8'h00};
        r_dst <= 16'hFE00;
        r_idx <= '0;
      end

      if (w_adv) begin
        r_src <= r_src + 16'd1;
        if (r_state == S_OAM_XFER) begin
          r_dst <= r_dst + 16'd1;
          r_idx <= r_idx + IW'(1);
        end else begin
          // VRAM destination wraps inside 8000-9FFF
          r_dst <= {3'b100, r_dst[12:0] + 13'd1};
          r_idx <= w_blk_last ? '0 : r_idx + IW'(1);
          if (w_blk_last) begin
            if (r_hlen == 7'd0) begin
              r_hact  <= 1'b0;
              r_hstop <= 1'b0;
            end else begin
              r_hlen <= r_hlen - 7'd1;
              if (r_state == S_HB_XFER && (r_cancel || w_cancel)) begin
                r_hact  <= 1'b0;
                r_hstop <= 1'b1;
              end
            end
          end
        end
      end

      if (r_state == S_HB_XFER && w_cancel) r_cancel <= 1'b1;
      if (r_state == S_HB_WAIT && w_cancel) begin
        r_hact  <= 1'b0;
        r_hstop <= 1'b1;
      end
    end
  end

  assign DMA_SRC_A = r_src;
  assign DMA_DST_A = r_dst;
  assign DMA_D_out = DMA_WR ? DMA_D_in : 8'h00;
  assign w_ff55    = r_hact ? {1'b0, r_hlen} : (r_hstop ? {1'b1, r_hlen} : 8'hFF);

  always_comb begin
    MMIO_DATA_in = 8'h00;
    if (RD) begin
      MMIO_DATA_in = 8'hFF;
      if (ADDR == 16'hFF46)                 MMIO_DATA_in = r_ff46;
      else if (HDMA_EN && ADDR == 16'hFF55) MMIO_DATA_in = w_ff55;
    end
  end
endmodule
